// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: request/status bundle between a FIFO user and fifo_ptr_ctrl.
//   master (user)  : drives write, read, flush (and err_clr), observes everything else
//   slave  (ctrl)  : drives wptr, rptr, fifo_write, fifo_read, level and status flags
//   FIFO_PTR_ERR_FLAGS_EN adds err_clr, overflow and underflow.
interface fifo_ptr_ctrl_if #(
    parameter int DEPTH      = 32,
    parameter int PTR_LENGTH = $clog2(DEPTH),
    parameter int CNT_LENGTH = $clog2(DEPTH + 1)
);
    logic                  write;
    logic                  read;
    logic                  flush;
    logic [PTR_LENGTH-1:0] wptr;
    logic [PTR_LENGTH-1:0] rptr;
    logic                  fifo_write;
    logic                  fifo_read;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_LENGTH-1:0] level;
`ifdef FIFO_PTR_ERR_FLAGS_EN
    logic                  err_clr;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write, read, flush, err_clr,
        input  wptr, rptr, fifo_write, fifo_read, fifo_full, fifo_empty,
               almost_full, almost_empty, level, overflow, underflow
    );
    modport slave (
        input  write, read, flush, err_clr,
        output wptr, rptr, fifo_write, fifo_read, fifo_full, fifo_empty,
               almost_full, almost_empty, level, overflow, underflow
    );
`else
    modport master (
        output write, read, flush,
        input  wptr, rptr, fifo_write, fifo_read, fifo_full, fifo_empty,
               almost_full, almost_empty, level
    );
    modport slave (
        input  write, read, flush,
        output wptr, rptr, fifo_write, fifo_read, fifo_full, fifo_empty,
               almost_full, almost_empty, level
    );
`endif
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointer, occupancy and status controller for a single-clock FIFO.
//   clk     : clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : fifo_ptr_ctrl_if.slave -- write/read/flush requests in; RAM addresses
//             (wptr/rptr), qualified enables, level and full/empty/almost flags out
//   Optional macro FIFO_PTR_ERR_FLAGS_EN adds err_clr input and sticky overflow/underflow.
//   Pointers wrap explicitly at DEPTH-1, so any DEPTH >= 2 is supported.
module fifo_ptr_ctrl #(
    parameter int DEPTH      = 32,
    parameter int PTR_LENGTH = $clog2(DEPTH),
    parameter int CNT_LENGTH = $clog2(DEPTH + 1),
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    fifo_ptr_ctrl_if.slave      bus
);
    if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_param_err
        $error("fifo_ptr_ctrl: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [PTR_LENGTH-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CNT_LENGTH-1:0] level_q, level_nxt;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  fifo_write, fifo_read;

    // A full FIFO is never empty, so a write while full succeeds exactly when the read does.
    assign fifo_read  = bus.read & ~empty_q & ~bus.flush;
    assign fifo_write = bus.write & (~full_q | bus.read) & ~bus.flush;

    always_comb begin
        wptr_nxt  = bus.flush ? '0 :
                    fifo_write ? ((wptr_q == PTR_LENGTH'(DEPTH - 1)) ? '0 : wptr_q + PTR_LENGTH'(1)) :
                    wptr_q;
        rptr_nxt  = bus.flush ? '0 :
                    fifo_read ? ((rptr_q == PTR_LENGTH'(DEPTH - 1)) ? '0 : rptr_q + PTR_LENGTH'(1)) :
                    rptr_q;
        level_nxt = bus.flush ? '0 :
                    (fifo_write & ~fifo_read) ? level_q + CNT_LENGTH'(1) :
                    (fifo_read & ~fifo_write) ? level_q - CNT_LENGTH'(1) :
                    level_q;
    end

    // Flags come from the next-state level so they always agree with level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_nxt;
            rptr_q  <= rptr_nxt;
            level_q <= level_nxt;
            full_q  <= level_nxt == CNT_LENGTH'(DEPTH);
            empty_q <= level_nxt == '0;
            af_q    <= level_nxt >= CNT_LENGTH'(AF_THRESH);
            ae_q    <= level_nxt <= CNT_LENGTH'(AE_THRESH);
        end
    end

    assign bus.wptr         = wptr_q;
    assign bus.rptr         = rptr_q;
    assign bus.level        = level_q;
    assign bus.fifo_full    = full_q;
    assign bus.fifo_empty   = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.fifo_write   = fifo_write;
    assign bus.fifo_read    = fifo_read;

`ifdef FIFO_PTR_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= (bus.write & ~fifo_write & ~bus.flush) | (ovf_q & ~bus.err_clr);
            unf_q <= (bus.read & empty_q & ~bus.flush) | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif
endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Parametrised pointer and status controller for the single-clock FIFOs feeding the systolic array edges. It combines read- and write-pointer management and supports any depth, including non-power-of-2 depths with explicit wrap. It also provides an occupancy count, full/empty and almost-full/almost-empty flags, and a synchronous flush. It drives the address and enable ports of a separate dual-port RAM; it holds no data itself.

Parameters:
DEPTH, 32, number of FIFO entries; legal range DEPTH >= 2, any integer.
PTR_LENGTH, $clog2(DEPTH), width of rptr/wptr.
CNT_LENGTH, $clog2(DEPTH+1), width of level.
AF_THRESH, DEPTH-4, almost_full asserted when level >= AF_THRESH.
AE_THRESH, 4, almost_empty asserted when level <= AE_THRESH.

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous reset, active-low
write  in  1  write request from producer
read  in  1  read request from consumer
flush  in  1  synchronous clear of pointers and level
wptr  out  PTR_LENGTH  RAM write address
rptr  out  PTR_LENGTH  RAM read address
fifo_write  out  1  qualified write enable to RAM
fifo_read  out  1  qualified read enable to RAM
fifo_full  out  1  level == DEPTH
fifo_empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  CNT_LENGTH  current occupancy

Behaviour:
- Reset (reset_n low, asynchronous): wptr=0, rptr=0, level=0, fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0. Any error flags clear.
- Release of reset is sampled synchronously. The first transfer is possible on the first clk edge with reset_n high.
- Qualification (combinational from registered flags and request inputs):
  - fifo_read = read & ~fifo_empty & ~flush.
  - fifo_write = write & (~fifo_full | read) & ~flush.
  - Write while full is accepted only if a read is accepted in the same cycle; the freed slot is reused.
  - Read while empty is always rejected, even with a simultaneous write. There is no fall-through; data is readable one cycle after the write.
- Pointer update:
  - On fifo_write, wptr increments; on fifo_read, rptr increments.
  - Wrap is explicit: value DEPTH-1 goes to 0, never through 2^PTR_LENGTH. This is required for non-power-of-2 DEPTH.
- Level update:
  - +1 on write only; -1 on read only.
  - Unchanged on both or on neither.
  - Never exceeds DEPTH and never goes below 0, by construction of the qualification.
- Flags:
  - Registered, computed from next-state level, updated on the same edge as level. Flags and level are therefore always mutually consistent.
  - No flag has combinational dependence on read/write.
- Flush:
  - Synchronous, highest priority after reset.
  - Next edge: wptr=rptr=0, level=0, flags as at reset.
  - Requests in the flush cycle are dropped, and fifo_read/fifo_write are 0 that cycle.
- Elaboration check: DEPTH >= 2 and 0 <= AE_THRESH < AF_THRESH <= DEPTH, else $error.
- Latency:
  - Request to qualified enable: 0 cycles (combinational).
  - Enable to pointer/level/flag update: 1 cycle.

Optional Feature:
Macro FIFO_PTR_ERR_FLAGS_EN.
- Defined, adds:
  - Input err_clr (1 bit).
  - Outputs overflow and underflow (1 bit each, sticky, reset 0).
  - overflow sets on the edge after write & ~fifo_write & ~flush (a rejected write). underflow sets on the edge after read & fifo_empty & ~flush.
  - err_clr clears both on the next edge. A set event in the same cycle as err_clr wins (flag stays 1).
- Undefined: the ports are absent and no error state exists.
- Pointer/level behaviour is identical in both builds.

Test Plan:
- DEPTH=5, AF=4, AE=1: write 5 consecutive cycles, no read. Required: level 1..5; almost_full on the edge where level=4; fifo_full at level=5; wptr sequence 1,2,3,4,0.
- Full FIFO (DEPTH=5), read=write=1 for 3 cycles. Required: fifo_write=fifo_read=1 every cycle, level stays 5, fifo_full stays 1, both pointers advance by 3 with wrap.
- Empty FIFO, read=write=1 for one cycle. Required: fifo_read=0, fifo_write=1; next edge level=1, fifo_empty=0, rptr unchanged.
- level=3, flush=1 with read=write=1. Required: fifo_read=fifo_write=0 that cycle; next edge wptr=rptr=0, level=0, fifo_empty=1, almost_empty=1.
- Mid-stream (level=2), assert reset_n=0 between clock edges. Required: all outputs return to reset values immediately, before the next clk edge.
- With FIFO_PTR_ERR_FLAGS_EN: write while full with read=0. Required: overflow=1 next edge, level stays DEPTH. Then err_clr=1 plus another rejected write: overflow stays 1. Then err_clr alone: overflow=0.
